// File: rtl/ncl_quad_sync_bridge_if.sv
// Signal bundle between a synchronous environment, the sync/NCL bridge and a quaternary NCL adder.
// The slave modport is the bridge's view; the master modport is the view of whatever surrounds it.
interface ncl_quad_sync_bridge_if #(
    parameter int DIGITS = 1
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*DIGITS-1:0]   a_in;
    logic [2*DIGITS-1:0]   b_in;
    logic                  cin;
    logic [4*DIGITS-1:0]   AQ;
    logic [4*DIGITS-1:0]   BQ;
    logic [1:0]            carryin;
    logic                  ABCOMP;
    logic [4*DIGITS-1:0]   sumQ;
    logic [1:0]            carryout;
    logic                  sumCOMP;
    logic                  carryCOMP;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*DIGITS-1:0]   sum_out;
    logic                  cout;
    logic                  err_illegal;
    logic                  err_timeout;

    modport slave (
        input  in_valid, a_in, b_in, cin, ABCOMP, sumQ, carryout, out_ready,
        output in_ready, AQ, BQ, carryin, sumCOMP, carryCOMP,
               out_valid, sum_out, cout, err_illegal, err_timeout
    );

    modport master (
        output in_valid, a_in, b_in, cin, ABCOMP, sumQ, carryout, out_ready,
        input  in_ready, AQ, BQ, carryin, sumCOMP, carryCOMP,
               out_valid, sum_out, cout, err_illegal, err_timeout
    );
endinterface

// File: rtl/ncl_quad_sync_bridge.sv
// Clocked shell around a quaternary NCL adder stage: binary valid/ready in, DATA/NULL
// wavefronts to the adder, synchronized completion detection back, binary valid/ready out.
module ncl_quad_sync_bridge #(
    parameter int DIGITS      = 1,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   init,
    ncl_quad_sync_bridge_if.slave  bus
);
    localparam int W  = 4*DIGITS + 3;          // {ABCOMP, carryout, sumQ}
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_DATA, WAIT_NULL, OUT} state_t;
    state_t state, state_next;

    logic [W-1:0]          sync_q [SYNC_STAGES];
    logic [W-1:0]          samp, samp_d;
    logic                  stable, word_data, word_null, word_illegal;
    logic                  res_data, res_null, ab_hi, ab_lo;
    logic [W-2:0]          res_word;
    logic [CW-1:0]         wait_cnt;
    logic                  load_data, capture, release_ack, waiting;

    function automatic logic one_hot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic multi_hot4(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

    function automatic logic [4*DIGITS-1:0] enc(input logic [2*DIGITS-1:0] v);
        enc = '0;
        for (int d = 0; d < DIGITS; d++) enc[4*d +: 4] = 4'b0001 << v[2*d +: 2];
    endfunction

    function automatic logic [2*DIGITS-1:0] dec(input logic [4*DIGITS-1:0] q);
        dec = '0;
        for (int d = 0; d < DIGITS; d++)
            for (int r = 0; r < 4; r++)
                if (q[4*d + r]) dec[2*d +: 2] = 2'(r);
    endfunction

    assign samp    = sync_q[SYNC_STAGES-1];
    // Two identical consecutive synchronized samples absorb skew between rails.
    assign stable  = (samp == samp_d);
    assign waiting = (state == WAIT_DATA) || (state == WAIT_NULL);

    always_comb begin
        word_data    = one_hot4({2'b00, samp[W-2:W-3]});
        word_null    = (samp[W-2:0] == '0);
        word_illegal = (samp[W-2:W-3] == 2'b11);
        for (int d = 0; d < DIGITS; d++) begin
            word_data    = word_data && one_hot4(samp[4*d +: 4]);
            word_illegal = word_illegal || multi_hot4(samp[4*d +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            // NOTE: the synchronizer chain is reset so a wavefront seen before init is never acted on.
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            samp_d   <= '0;
            res_data <= 1'b0;
            res_null <= 1'b0;
            ab_hi    <= 1'b0;
            ab_lo    <= 1'b0;
            res_word <= '0;
        end else begin
            sync_q[0] <= {bus.ABCOMP, bus.carryout, bus.sumQ};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            samp_d   <= samp;
            res_data <= stable && word_data;
            res_null <= stable && word_null;
            ab_hi    <= stable && samp[W-1];
            ab_lo    <= stable && !samp[W-1];
            if (stable && word_data) res_word <= samp[W-2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (init) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first, so no path can infer a latch.
        state_next  = state;
        load_data   = 1'b0;
        capture     = 1'b0;
        release_ack = 1'b0;
        case (state)
            IDLE:      if (bus.in_ready && bus.in_valid) begin
                           state_next = WAIT_DATA;
                           load_data  = 1'b1;
                       end
            WAIT_DATA: if (res_data && ab_hi) begin
                           state_next = WAIT_NULL;
                           capture    = 1'b1;
                       end
            WAIT_NULL: if (res_null && ab_lo) begin
                           state_next  = OUT;
                           release_ack = 1'b1;
                       end
            OUT:       if (bus.out_ready) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            bus.AQ          <= '0;
            bus.BQ          <= '0;
            bus.carryin     <= '0;
            bus.sumCOMP     <= 1'b0;
            bus.carryCOMP   <= 1'b0;
            bus.in_ready    <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.sum_out     <= '0;
            bus.cout        <= 1'b0;
            bus.err_illegal <= 1'b0;
        end else begin
            bus.in_ready  <= (state_next == IDLE);
            bus.out_valid <= (state_next == OUT);
            if (load_data) begin
                bus.AQ      <= enc(bus.a_in);
                bus.BQ      <= enc(bus.b_in);
                bus.carryin <= bus.cin ? 2'b10 : 2'b01;
            end
            if (capture) begin
                bus.AQ        <= '0;
                bus.BQ        <= '0;
                bus.carryin   <= '0;
                bus.sum_out   <= dec(res_word[4*DIGITS-1:0]);
                bus.cout      <= res_word[W-2];
                bus.sumCOMP   <= 1'b1;
                bus.carryCOMP <= 1'b1;
            end
            if (release_ack) begin
                bus.sumCOMP   <= 1'b0;
                bus.carryCOMP <= 1'b0;
            end
            if (stable && word_illegal) bus.err_illegal <= 1'b1;
        end
    end

    // Wait counter restarts on every state change and saturates at TIMEOUT.
    always_ff @(posedge clk) begin
        if (init) begin
            wait_cnt        <= '0;
            bus.err_timeout <= 1'b0;
        end else begin
            if (state_next != state)
                wait_cnt <= '0;
            else if (waiting && wait_cnt != CW'(TIMEOUT))
                wait_cnt <= wait_cnt + CW'(1);
            if (waiting && wait_cnt == CW'(TIMEOUT)) bus.err_timeout <= 1'b1;
        end
    end
endmodule

// File: doc/ncl_quad_sync_bridge.md
Name: ncl_quad_sync_bridge

Overview:
- Clocked environment shell for the quaternary (1-of-4) NCL full-adder stage.
- Accepts binary operands on a valid/ready interface and drives them into the adder as DATA/NULL wavefronts on AQ/BQ/carryin.
- Runs the completion handshake from the opposite end: consumes ABCOMP, drives sumCOMP/carryCOMP, and returns binary results on a valid/ready interface.
- Used for synchronous benches and for any sync-to-NCL boundary.

Parameters:
- DIGITS, 1: number of quaternary digits driven and collected; the chain ripple is external.
- SYNC_STAGES, 2: flop depth of the synchronizer on every asynchronous input (min 2).
- TIMEOUT, 255: cycles allowed in any wait state before err_timeout is raised.

Ports:
- clk  input  1  system clock
- init  input  1  synchronous active-high reset
- in_valid  input  1  operand word valid
- in_ready  output  1  bridge can accept operands
- a_in  input  2*DIGITS  operand A, binary, 2 bits per digit
- b_in  input  2*DIGITS  operand B, binary
- cin  input  1  carry in
- AQ  output  4*DIGITS  operand A, 1-of-4 per digit
- BQ  output  4*DIGITS  operand B, 1-of-4 per digit
- carryin  output  2  carry in, dual-rail (rail0 = 0, rail1 = 1)
- ABCOMP  input  1  adder input-side completion (async)
- sumQ  input  4*DIGITS  adder sum, 1-of-4 per digit (async)
- carryout  input  2  adder carry out, dual-rail (async)
- sumCOMP  output  1  sum consumed acknowledge
- carryCOMP  output  1  carry consumed acknowledge
- out_valid  output  1  result valid
- out_ready  input  1  result accepted
- sum_out  output  2*DIGITS  result, binary
- cout  output  1  carry out, binary
- err_illegal  output  1  sticky: multi-hot code seen
- err_timeout  output  1  sticky: wait exceeded TIMEOUT

Behaviour:
- Reset (init=1 at a clk edge):
  - state=IDLE, AQ=BQ=0 and carryin=0 (NULL), sumCOMP=carryCOMP=0.
  - in_ready=0, out_valid=0, sum_out=0, cout=0, err flags=0.
  - Synchronizers and timeout counter cleared.
  - init mid-operation aborts immediately and forces NULL on the next edge; the adder is left to drain.
- Synchronizers: ABCOMP, sumQ and carryout each pass through SYNC_STAGES flops. A condition is acted on only after identical synchronized samples on 2 consecutive cycles, which absorbs rail skew.
- Encoding: digit value v drives rail v of that digit. cin=0 drives carryin=2'b01; cin=1 drives 2'b10. Decoding is the inverse (one-hot index).
- Output flags (registered):
  - RES_DATA: every sum digit has exactly one rail high and carryout has exactly one rail high.
  - RES_NULL: sumQ and carryout are all zero.
- FSM, one transition per clk:
  - IDLE: in_ready=1. When in_valid is high, latch the operands, register the encoded DATA onto AQ/BQ/carryin, and go to WAIT_DATA.
  - WAIT_DATA: hold DATA. Leave when RES_DATA and ABCOMP_s=1. On leaving, capture the decoded result into sum_out/cout, set sumCOMP=carryCOMP=1 and AQ/BQ/carryin=0, and go to WAIT_NULL.
  - WAIT_NULL: hold NULL and acks high. Leave when RES_NULL and ABCOMP_s=0. On leaving, clear sumCOMP/carryCOMP and go to OUT.
  - OUT: out_valid=1 with sum_out/cout stable. When out_ready is high, go to IDLE; in_ready rises on the next cycle.
- Handshakes:
  - in_ready is 1 only in IDLE.
  - No new DATA is presented until the previous NULL wavefront has completed, so DATA and NULL always alternate.
- err_illegal: set when any digit has 2 or more rails high, or carryout=2'b11, on a synchronized sample. State is unaffected; the FSM keeps waiting.
- err_timeout: set when the cycle counter in WAIT_DATA or WAIT_NULL reaches TIMEOUT. The FSM stays in that state. The counter clears on every state change.
- Simultaneous events: out_ready together with in_valid in OUT does not accept the new operands (in_ready=0). RES_DATA and RES_NULL are mutually exclusive by definition.
- Minimum latency from in_valid accepted to out_valid: 2*(SYNC_STAGES+2)+2 cycles, assuming a zero-delay adder.

Test Plan:
- DIGITS=1, a_in=3, b_in=2, cin=1 -> AQ=4'b1000, BQ=4'b0100, carryin=2'b10. Then sum_out=2'b10, cout=1, out_valid high, and sumCOMP pulses high across the NULL phase.
- a_in=0, b_in=0, cin=0 -> AQ=BQ=4'b0001, carryin=2'b01, sum_out=0, cout=0. Repeat for all 32 operand combinations (4×4×2) against a+b+cin.
- Hold out_ready=0 for 10 cycles in OUT -> out_valid and sum_out stay stable, in_ready=0, AQ stays NULL.
- Stub adder never asserts ABCOMP -> err_timeout=1 after 255 cycles in WAIT_DATA, and state stays in WAIT_DATA.
- Stub forces sumQ=4'b0110 -> err_illegal=1 (sticky), no capture, and it stays in WAIT_DATA.
- init pulsed during WAIT_NULL -> the next cycle has all outputs at reset values and in_ready=0. After init falls, in_ready=1 and a fresh transaction completes correctly.
